// File: rtl/commit_trace_buffer_pkg.sv
// Shared trace types: event kinds and the packed entry carried through the capture FIFO.
package trace_pkg;
  localparam int TRACE_STAMP_W = 16;
  localparam int TRACE_IDX_W   = 9;
  localparam int TRACE_DATA_W  = 32;

  typedef enum logic [1:0] {
    REG   = 2'd0,
    STORE = 2'd1,
    MARK  = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e                kind;
    logic [TRACE_IDX_W-1:0]     idx;
    logic [TRACE_DATA_W-1:0]    data;
    logic [TRACE_STAMP_W-1:0]   stamp;
  } trace_entry_t;
endpackage

// File: rtl/commit_trace_buffer_if.sv
// Capture taps from the datapath plus the drain stream and status of the trace buffer.
interface commit_trace_buffer_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int DEPTH      = 16
);
  import trace_pkg::*;

  logic                     enable;
  logic                     reg_write_sig;
  logic [4:0]               reg_num;
  logic [DATA_W-1:0]        reg_data;
  logic                     wr;
  logic [DM_ADDRESS-1:0]    addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     out_valid;
  logic                     out_ready;
  trace_entry_t             out_entry;
  logic [$clog2(DEPTH):0]   level;
  logic [15:0]              drop_count;

  modport slave (
    input  enable, reg_write_sig, reg_num, reg_data, wr, addr, wr_data, out_ready,
    output out_valid, out_entry, level, drop_count
  );

  modport master (
    output enable, reg_write_sig, reg_num, reg_data, wr, addr, wr_data, out_ready,
    input  out_valid, out_entry, level, drop_count
  );
endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// Dual-push, single-pop first-word-fall-through FIFO; a push is readable the cycle after it lands.
// Never refuses: the caller must only push into free slots and only pop when level is non-zero.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0_vld,
  input  trace_entry_t           push0_dat,
  input  logic                   push1_vld,
  input  trace_entry_t           push1_dat,
  input  logic                   pop,
  output trace_entry_t           head_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  trace_entry_t     mem_q [DEPTH];
  trace_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // push1 is only ever used alongside push0, so it always lands one slot after it.
  always_comb begin
    mem_d = mem_q;
    if (push0_vld) mem_d[wptr_q] = push0_dat;
    if (push1_vld) mem_d[wptr_q + PTR_W'(1)] = push1_dat;
    wptr_d  = wptr_q + PTR_W'(push0_vld) + PTR_W'(push1_vld);
    rptr_d  = rptr_q + PTR_W'(pop);
    level_d = level_q + LVL_W'(push0_vld) + LVL_W'(push1_vld) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign head_dat = (level_q != '0) ? mem_q[rptr_q] : '0;
  assign level    = level_q;
endmodule

// File: rtl/commit_trace_buffer.sv
// Timestamps REG writebacks and STOREs into a trace FIFO; entries are visible the cycle after capture.
// Never stalls the datapath: events that do not fit are dropped, counted and later reported by a MARK entry.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int DEPTH      = 16,
  parameter int STAMP_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  commit_trace_buffer_if.slave bus
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [LVL_W-1:0]      level, free;
  logic [1:0]            slots, n_push, n_drop, push_vld;
  trace_entry_t          push_ent [2];
  trace_entry_t          cand_ent [3];
  trace_entry_t          head;
  logic [2:0]            cand_vld;
  logic                  mark_sent, ev_reg, ev_st, pop;
  logic [DM_ADDRESS-1:0] st_addr;
  logic [STAMP_W-1:0]    stamp_q, stamp_d;
  logic [15:0]           drop_count_q, drop_count_d;
  logic [16:0]           drop_sum;
  logic [DATA_W-1:0]     tally_q, tally_d, tally_base;
  logic [DATA_W:0]       tally_sum;
  logic                  mark_pending_q, mark_pending_d;

  assign st_addr = bus.addr;
  assign pop     = (level != '0) && bus.out_ready;
  // Free space comes from the registered level; a same-cycle pop is not credited.
  assign free    = LVL_W'(DEPTH) - level;
  assign slots   = (free >= LVL_W'(2)) ? 2'd2 : free[1:0];

  always_comb begin
    ev_reg   = bus.enable && bus.reg_write_sig && (bus.reg_num != 5'd0);
    ev_st    = bus.enable && bus.wr;
    cand_vld = {ev_st, ev_reg, mark_pending_q};
    cand_ent[0] = '{kind: MARK, idx: '0, data: TRACE_DATA_W'(tally_q),
                    stamp: TRACE_STAMP_W'(stamp_q)};
    cand_ent[1] = '{kind: REG, idx: TRACE_IDX_W'(bus.reg_num),
                    data: TRACE_DATA_W'(bus.reg_data), stamp: TRACE_STAMP_W'(stamp_q)};
    cand_ent[2] = '{kind: STORE, idx: TRACE_IDX_W'(st_addr),
                    data: TRACE_DATA_W'(bus.wr_data), stamp: TRACE_STAMP_W'(stamp_q)};
    n_push      = 2'd0;
    n_drop      = 2'd0;
    push_vld    = 2'b00;
    push_ent[0] = '0;
    push_ent[1] = '0;
    mark_sent   = 1'b0;
    // Fill slots in priority order; an unplaced marker simply stays pending.
    for (int i = 0; i < 3; i++) begin
      if (cand_vld[i]) begin
        if (n_push < slots) begin
          push_vld[n_push[0]] = 1'b1;
          push_ent[n_push[0]] = cand_ent[i];
          n_push = n_push + 2'd1;
          if (i == 0) mark_sent = 1'b1;
        end else if (i != 0) begin
          n_drop = n_drop + 2'd1;
        end
      end
    end
    drop_sum       = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    tally_base     = mark_sent ? '0 : tally_q;
    tally_sum      = {1'b0, tally_base} + (DATA_W+1)'(n_drop);
    tally_d        = tally_sum[DATA_W] ? '1 : tally_sum[DATA_W-1:0];
    mark_pending_d = (mark_pending_q && !mark_sent) || (n_drop != 2'd0);
    stamp_d        = stamp_q + STAMP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stamp_q        <= '0;
      drop_count_q   <= '0;
      tally_q        <= '0;
      mark_pending_q <= 1'b0;
    end else begin
      stamp_q        <= stamp_d;
      drop_count_q   <= drop_count_d;
      tally_q        <= tally_d;
      mark_pending_q <= mark_pending_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push0_vld (push_vld[0]),
    .push0_dat (push_ent[0]),
    .push1_vld (push_vld[1]),
    .push1_dat (push_ent[1]),
    .pop       (pop),
    .head_dat  (head),
    .level     (level)
  );

  assign bus.out_valid  = (level != '0);
  assign bus.out_entry  = head;
  assign bus.level      = level;
  assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomised and directed stimulus for commit_trace_buffer, scored against a queue-based reference model.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  commit_trace_buffer_if #(.DATA_W(32), .DM_ADDRESS(9), .DEPTH(DEPTH)) bus ();

  commit_trace_buffer #(
    .DATA_W(32), .DM_ADDRESS(9), .DEPTH(DEPTH), .STAMP_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  trace_entry_t exp_q [$];
  int           mdl_level = 0;
  int           mdl_drops = 0;
  longint       mdl_tally = 0;
  bit           mdl_mpend = 1'b0;
  int           mdl_stamp = 0;
  bit           mon_en    = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each captured edge, build the ordered wish list (marker, REG, STORE),
  // keep as many as the pre-pop room allows (at most two), and account for the rest as drops.
  always @(posedge clk) begin : model
    trace_entry_t c [$];
    int  room, pushed, nd;
    bit  popd, msent;
    if (!reset) begin
      exp_q.delete();
      mdl_level = 0;
      mdl_drops = 0;
      mdl_tally = 0;
      mdl_mpend = 1'b0;
      mdl_stamp = 0;
    end else begin
      popd = (mdl_level != 0) && (bus.out_ready === 1'b1);
      room = DEPTH - mdl_level;
      if (room > 2) room = 2;
      c.delete();
      if (mdl_mpend)
        c.push_back('{kind: MARK, idx: 9'd0, data: 32'(mdl_tally), stamp: 16'(mdl_stamp)});
      if (bus.enable && bus.reg_write_sig && bus.reg_num != 5'd0)
        c.push_back('{kind: REG, idx: 9'(bus.reg_num), data: bus.reg_data, stamp: 16'(mdl_stamp)});
      if (bus.enable && bus.wr)
        c.push_back('{kind: STORE, idx: bus.addr, data: bus.wr_data, stamp: 16'(mdl_stamp)});
      pushed = 0;
      nd     = 0;
      msent  = 1'b0;
      foreach (c[i]) begin
        if (pushed < room) begin
          exp_q.push_back(c[i]);
          pushed++;
          if (c[i].kind == MARK) msent = 1'b1;
        end else if (c[i].kind != MARK) begin
          nd++;
        end
      end
      if (msent) begin
        mdl_tally = 0;
        mdl_mpend = 1'b0;
      end
      if (nd > 0) begin
        mdl_drops = (mdl_drops + nd > 65535) ? 65535 : mdl_drops + nd;
        mdl_tally = (mdl_tally + nd > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mdl_tally + nd;
        mdl_mpend = 1'b1;
      end
      mdl_level = mdl_level + pushed - (popd ? 1 : 0);
      mdl_stamp = (mdl_stamp + 1) % 65536;
    end
  end

  // Monitor: checks the visible head against the scoreboard and retires it on a handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(bus.out_valid), 64'(mdl_level != 0));
      chk("level", 64'(bus.level), 64'(mdl_level));
      chk("drop_count", 64'(bus.drop_count), 64'(mdl_drops));
      if (mdl_level != 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty: got valid head expected queued entry (t=%0t)", $time);
        end else begin
          chk("out_entry", 64'(bus.out_entry), 64'(exp_q[0]));
          if (bus.out_ready && reset) void'(exp_q.pop_front());
        end
      end else begin
        chk("empty_entry", 64'(bus.out_entry), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_write_sig = 1'b0;
    bus.wr            = 1'b0;
  endtask

  task automatic drive(input bit rw, input logic [4:0] rn, input logic [31:0] rd,
                       input bit w, input logic [8:0] a, input logic [31:0] wd);
    bus.reg_write_sig = rw;
    bus.reg_num       = rn;
    bus.reg_data      = rd;
    bus.wr            = w;
    bus.addr          = a;
    bus.wr_data       = wd;
  endtask

  task automatic drain_all();
    int k;
    idle();
    bus.out_ready = 1'b1;
    k = 0;
    while (bus.level != '0 && k < 200) begin
      tick();
      k++;
    end
    if (bus.level != '0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got level %0d expected 0", bus.level);
    end
    bus.out_ready = 1'b0;
    tick();
  endtask

  trace_entry_t e;

  initial begin
    bus.enable = 1'b1;
    bus.out_ready = 1'b0;
    drive(0, 5'd0, 32'd0, 0, 9'd0, 32'd0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_entry", 64'(bus.out_entry), 64'd0);
    chk("rst_drops", 64'(bus.drop_count), 64'd0);
    reset = 1'b1;

    // Single REG captured at stamp 3
    repeat (3) tick();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 9'd0, 32'd0);
    tick();
    idle();
    e = '{kind: REG, idx: 9'd5, data: 32'hDEADBEEF, stamp: 16'd3};
    chk("single_reg_entry", 64'(bus.out_entry), 64'(e));
    chk("single_reg_level", 64'(bus.level), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // x0 writeback filtered, then a REG+STORE pair in one cycle
    drive(1, 5'd0, 32'h1234, 1, 9'h010, 32'd7);
    tick();
    drive(1, 5'd3, 32'h33, 1, 9'h020, 32'h44);
    tick();
    idle();
    chk("dual_level", 64'(bus.level), 64'd3);
    drain_all();

    // Overflow: 9 dual cycles with no drain
    for (int i = 0; i < 9; i++) begin
      drive(1, 5'($urandom_range(1, 31)), $urandom, 1, 9'($urandom), $urandom);
      tick();
    end
    idle();
    chk("ovf_level", 64'(bus.level), 64'd16);
    chk("ovf_drops", 64'(bus.drop_count), 64'd2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(1, 5'd7, 32'h77, 0, 9'd0, 32'd0);
    tick();
    idle();
    chk("ovf_drops_after", 64'(bus.drop_count), 64'd3);
    chk("ovf_level_after", 64'(bus.level), 64'd16);
    drain_all();

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1), 9'($urandom), $urandom);
      bus.out_ready = $urandom_range(0, 1);
      tick();
    end
    bus.enable = 1'b1;
    drain_all();

    // Reset mid-stream with 7 entries held
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 1), 32'(i), 1, 9'(i), 32'(i));
      tick();
    end
    drive(1, 5'd4, 32'h4, 0, 9'd0, 32'd0);
    tick();
    idle();
    chk("mid_level", 64'(bus.level), 64'd7);
    reset = 1'b0;
    tick();
    chk("mid_rst_level", 64'(bus.level), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_drops", 64'(bus.drop_count), 64'd0);
    reset = 1'b1;
    drive(1, 5'd9, 32'h99, 0, 9'd0, 32'd0);
    tick();
    idle();
    e = '{kind: REG, idx: 9'd9, data: 32'h99, stamp: 16'd0};
    chk("post_rst_entry", 64'(bus.out_entry), 64'(e));
    drain_all();

    // Stamp wrap
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (65535) tick();
    drive(1, 5'd1, 32'hA, 0, 9'd0, 32'd0);
    tick();
    drive(1, 5'd2, 32'hB, 0, 9'd0, 32'd0);
    tick();
    idle();
    e = '{kind: REG, idx: 9'd1, data: 32'hA, stamp: 16'hFFFF};
    chk("wrap_ffff", 64'(bus.out_entry), 64'(e));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    e = '{kind: REG, idx: 9'd2, data: 32'hB, stamp: 16'h0000};
    chk("wrap_zero", 64'(bus.out_entry), 64'(e));
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
